// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding and default limits for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - loadable down-counter that expires when it reaches zero while enabled
module mem_arb_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = en && (count == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for the shared single-port memory
// Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    // Loading TIMEOUT-1 makes expiry land on the TIMEOUT-th grant cycle.
    localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT - 1);

    arb_state_t state, next_state;
    logic grant_i, grant_d, finish, timed_out;
    logic owner_d, starve_hit, in_grant, wd_expire;

    assign in_grant = (state == GNT_I) || (state == GNT_D);

    mem_arb_watchdog #(.WIDTH(TW)) u_watchdog (
        .clk        (Clk),
        .rst        (Rst),
        .clear      (state == DONE),
        .load       (grant_i || grant_d),
        .en         (in_grant),
        .load_value (WD_LOAD),
        .expire     (wd_expire)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign starve_hit = (starve_cnt == STARVE_LIM);
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_hit)) begin
                    next_state = GNT_D;
                    grant_d    = 1'b1;
                end else if (if_req) begin
                    next_state = GNT_I;
                    grant_i    = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ack) begin
                    next_state = DONE;
                    finish     = 1'b1;
                end else if (wd_expire) begin
                    next_state = DONE;
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            owner_d     <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
                owner_d <= 1'b0;
            end else if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                owner_d <= 1'b1;
            end else if (finish) begin
                m_req <= 1'b0;
            end
            // An aborted access returns zero so the stage never sees stale data.
            if (finish && (state == GNT_I)) begin
                if_rdata <= timed_out ? '0 : m_rdata;
            end
            if (finish && (state == GNT_D)) begin
                d_rdata <= timed_out ? '0 : m_rdata;
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign if_done   = (state == DONE) && !owner_d;
    assign d_done    = (state == DONE) && owner_d;
    assign stall_if  = if_req && !if_done;
    assign stall_mem = d_req && !d_done;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the pipeline's instruction-fetch (IF) stage and the load/store (MEM) stage of the ARMv8 core. Data accesses win by default because they belong to the older instruction; a starvation guard bounds how long fetch can be locked out. Stall outputs hold the losing stage; a watchdog flags a memory that never acknowledges. The block sits between the pipeline stages and the memory model used by the system test bench.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT, 255, max cycles waiting for m_ack before abort (≥1)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)
---
- Clk  in  1  clock; the block's only clock
- Rst  in  1  reset, synchronous and active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetch data, valid with if_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  load data, valid with d_done
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  d_req & ~d_done (combinational)
- m_req, m_we  out  1  memory request / write enable
- m_addr, m_wdata  out  ADDR_W / DATA_W  memory address / write data
- m_ack  in  1  one-cycle acknowledge; m_rdata valid in that cycle
- m_rdata  in  DATA_W  memory read data
- err_timeout  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE.
- IDLE: both requests pending → GNT_D, unless the starvation guard fires → GNT_I. Single request → its grant. Neither → stay.
- Entering GNT_x registers m_req=1 and m_we/m_addr/m_wdata from the winner; all held stable until exit. m_we=0 for fetch.
- GNT_x with m_ack → DONE; m_rdata captured into x_rdata, m_req drops.
- DONE (exactly one cycle): x_done=1; requests ignored; → IDLE.
- Starvation counter: +1 on each data grant while if_req is pending, cleared on a fetch grant; fetch forced when count == STARVE_MAX.
- Watchdog: counts cycles in GNT_x; at TIMEOUT without m_ack → err_timeout=1 (sticky until Rst), m_req drops, DONE with x_done=1 and x_rdata=0.
- m_ack in IDLE/DONE is ignored.
- Reset values: all outputs 0, state IDLE, counters 0, rdata registers 0.

## Timing
- Request visible in IDLE at cycle N → m_req high at N+1.
- m_ack at cycle N+1+L (L≥0) → x_done at N+2+L. Minimum request→done latency: 2 cycles.
- Back-to-back same requester: next grant earliest 2 cycles after done (DONE, IDLE).
- Rst mid-transaction: next cycle state IDLE, m_req=0, no done pulse; err_timeout cleared.
- stall_* follow their inputs in the same cycle.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starvation counter active as above.
- Undefined: strict data priority; counter logic removed; fetch can starve indefinitely.

## Structure
- Package mem_arb_pkg: FSM state encoding (IDLE, GNT_I, GNT_D, DONE), default TIMEOUT/STARVE_MAX constants.
- Sub-module mem_arb_watchdog: loadable down-counter with clear and expire output; instanced once.

## Test plan
- Fetch only, if_addr=0x10, m_ack one cycle after m_req, m_rdata=0xAA → m_addr=0x10, if_done two cycles later with if_rdata=0xAA, stall_if high until then.
- if_req and d_req (store 0x2 to 0x20) rise together → data granted first, m_we=1, m_wdata=0x2; fetch served after d_done.
- d_req held continuously with if_req pending, STARVE_MAX=4, guard enabled → fetch granted after exactly 4 data grants; with the macro undefined, fetch is never granted.
- m_ack never asserted, TIMEOUT=8 → m_req drops after 8 grant cycles, err_timeout=1, done pulse with rdata=0; flag persists until Rst.
- Rst asserted while in GNT_D → next cycle m_req=0 and all outputs 0; a late m_ack produces no done pulse.
- m_ack pulsed while IDLE → no state change, no done pulse.
